// File: rtl/pulse_req_tx.sv
// pulse_req_tx: source side of a four-phase req/ack pulse crossing, clocked on clka.
// Each accepted pulse on pulse_ina becomes a request level on req_a. The request
// is held until the synchronised acknowledge rises, and the handshake finishes
// when the acknowledge falls again. Pulses that arrive while a handshake is in
// flight are flagged on drop_a and counted, saturating, on drop_cnt_a.
//
// Optional build macro: PULSE_PEND_EN
//   When defined, one pulse arriving while busy is held in a pending flag. It
//   starts a new handshake directly from the RELEASE exit, with no IDLE cycle.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | no handshake in flight; the only state in which a pulse is accepted
// REQ     | req_a high; waiting for the synchronised ack to rise
// RELEASE | req_a low; waiting for the synchronised ack to fall

module pulse_req_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             pulse_ina,
    input  logic             ack_b,
    output logic             req_a,
    output logic             busy_a,
    output logic             done_a,
    output logic             drop_a,
    output logic [CNT_W-1:0] drop_cnt_a
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   drop_evt;
`ifdef PULSE_PEND_EN
    logic                   pend;
`endif

    // ack_b crosses into clka through a plain flop chain; nothing else looks at ack_b
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_b};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // A pulse is discarded whenever it is sampled outside IDLE and cannot be parked
    always_comb begin
        drop_evt = 1'b0;
        if (pulse_ina && (state != ST_IDLE)) begin
`ifdef PULSE_PEND_EN
            // With the pending slot free the pulse is parked or, on the exit edge,
            // starts the next handshake directly; only a full slot loses it.
            drop_evt = pend;
`else
            drop_evt = 1'b1;
`endif
        end
    end

    // Handshake sequencer with registered req/busy/done/drop outputs
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            req_a  <= 1'b0;
            busy_a <= 1'b0;
            done_a <= 1'b0;
            drop_a <= 1'b0;
`ifdef PULSE_PEND_EN
            pend   <= 1'b0;
`endif
        end else begin
            done_a <= 1'b0;
            drop_a <= drop_evt;
            case (state)
                ST_IDLE: begin
                    // A stale ack left over from a reset is ignored here; REQ will
                    // see it and move straight on to RELEASE.
                    if (pulse_ina) begin
                        state  <= ST_REQ;
                        req_a  <= 1'b1;
                        busy_a <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (ack_s) begin
                        state <= ST_RELEASE;
                        req_a <= 1'b0;
                    end
`ifdef PULSE_PEND_EN
                    if (pulse_ina && !pend) begin
                        pend <= 1'b1;
                    end
`endif
                end

                ST_RELEASE: begin
                    if (!ack_s) begin
                        done_a <= 1'b1;
`ifdef PULSE_PEND_EN
                        // Chain straight into the next request so busy_a never dips
                        if (pend || pulse_ina) begin
                            state <= ST_REQ;
                            req_a <= 1'b1;
                            pend  <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            busy_a <= 1'b0;
                        end
`else
                        state  <= ST_IDLE;
                        busy_a <= 1'b0;
`endif
                    end
`ifdef PULSE_PEND_EN
                    else if (pulse_ina && !pend) begin
                        pend <= 1'b1;
                    end
`endif
                end

                default: begin
                    state  <= ST_IDLE;
                    req_a  <= 1'b0;
                    busy_a <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of discarded pulses; holds at all-ones instead of wrapping
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_a <= '0;
        end else if (drop_evt && (drop_cnt_a != CNT_MAX)) begin
            drop_cnt_a <= drop_cnt_a + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pulse_req_tx.sv
// Bench for pulse_req_tx: directed scenarios plus a randomized run against a
// behavioural model of the handshake kept in the bench.

module tb_pulse_req_tx;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    logic             clka      = 1'b0;
    logic             rst_n     = 1'b0;
    logic             pulse_ina = 1'b0;
    logic             ack_b     = 1'b0;
    logic             req_a;
    logic             busy_a;
    logic             done_a;
    logic             drop_a;
    logic [CNT_W-1:0] drop_cnt_a;

    int errors = 0;
    int checks = 0;

    always #5 clka = ~clka;

    pulse_req_tx #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clka      (clka),
        .rst_n     (rst_n),
        .pulse_ina (pulse_ina),
        .ack_b     (ack_b),
        .req_a     (req_a),
        .busy_a    (busy_a),
        .done_a    (done_a),
        .drop_a    (drop_a),
        .drop_cnt_a(drop_cnt_a)
    );

    // ---------------- behavioural model ----------------
    bit         m_busy, m_req, m_pend, m_done, m_drop;
    bit [1:0]   m_hist;      // ack_b as seen through the two-edge delay
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_busy = 0; m_req = 0; m_pend = 0; m_done = 0; m_drop = 0;
        m_hist = 2'b00; m_cnt = 8'd0;
    endtask

    // One clka edge: p = pulse, a = ack_b present at that edge
    task automatic model_edge(input bit p, input bit a);
        bit seen;
        bit lost;
        seen   = m_hist[1];
        m_hist = {m_hist[0], a};
        m_done = 0;
        lost   = 0;
        if (!m_busy) begin
            if (p) begin
                m_busy = 1;
                m_req  = 1;
            end
        end else if (!m_req && !seen) begin
            m_done = 1;
`ifdef PULSE_PEND_EN
            if (m_pend || p) begin
                lost   = m_pend && p;
                m_req  = 1;
                m_pend = 0;
            end else begin
                m_busy = 0;
            end
`else
            m_busy = 0;
            lost   = p;
`endif
        end else begin
            if (m_req && seen) m_req = 0;
            if (p) begin
`ifdef PULSE_PEND_EN
                if (m_pend) lost = 1;
                else        m_pend = 1;
`else
                lost = 1;
`endif
            end
        end
        m_drop = lost;
        if (lost && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    endtask

    // ---------------- responder ----------------
    int resp_mode  = 0;   // 0 follows req_a after a delay, 1 stalls at 0, 2 manual
    int resp_cnt   = 0;
    int resp_delay = 3;
    bit resp_rand  = 0;

    task automatic respond();
        if (resp_mode == 1) begin
            ack_b = 1'b0;
        end else if (resp_mode == 0) begin
            if (req_a != ack_b) begin
                resp_cnt++;
                if (resp_cnt >= resp_delay) begin
                    ack_b    = req_a;
                    resp_cnt = 0;
                    if (resp_rand) resp_delay = $urandom_range(1, 6);
                end
            end else begin
                resp_cnt = 0;
            end
        end
    endtask

    // Called at a negedge: apply pulse, take one edge, land on next negedge
    task automatic step(input bit p);
        bit a;
        pulse_ina = p;
        a = ack_b;
        @(posedge clka);
        model_edge(p, a);
        @(negedge clka);
        pulse_ina = 1'b0;
        respond();
    endtask

    task automatic do_reset();
        @(negedge clka);
        rst_n     = 1'b0;
        pulse_ina = 1'b0;
        ack_b     = 1'b0;
        resp_cnt  = 0;
        @(posedge clka);
        @(negedge clka);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] obs;
        pulse_ina = 1'b1;
        ack_b     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            obs = {req_a, busy_a, done_a, drop_a, drop_cnt_a};
            checks++;
            if (obs !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h want 000", i, obs);
            end
        end
        pulse_ina = 1'b0;
        ack_b     = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            obs = {req_a, busy_a, done_a, drop_a, drop_cnt_a};
            checks++;
            if (obs !== 12'h000) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h want 000", i, obs);
            end
        end
    endtask

    task automatic test_single();
        int req_hi, busy_hi, done_n, done_idx, idle_idx;
        do_reset();
        resp_mode = 0; resp_delay = 3; resp_rand = 0;
        for (int i = 0; i < 9; i++) step(1'b0);
        step(1'b1);
        req_hi = 0; busy_hi = 0; done_n = 0; done_idx = -1; idle_idx = -1;
        for (int i = 0; i < 30; i++) begin
            if (req_a) req_hi++;
            if (busy_a) busy_hi++;
            if (done_a) begin done_n++; if (done_idx < 0) done_idx = i; end
            if (!busy_a && idle_idx < 0) idle_idx = i;
            step(1'b0);
        end
        checks++;
        if (req_hi != 5) begin errors++; $display("FAIL single_req_len: got %0d want 5", req_hi); end
        checks++;
        if (busy_hi != 10) begin errors++; $display("FAIL single_busy_len: got %0d want 10", busy_hi); end
        checks++;
        if (done_n != 1 || done_idx != 10) begin
            errors++; $display("FAIL single_done: got count %0d at %0d want 1 at 10", done_n, done_idx);
        end
        checks++;
        if (idle_idx != 10) begin errors++; $display("FAIL single_busy_end: got %0d want 10", idle_idx); end
        checks++;
        if (drop_cnt_a !== 8'd0) begin errors++; $display("FAIL single_drop_cnt: got %0d want 0", drop_cnt_a); end
    endtask

    task automatic test_three_pulses();
        int rises, dones, drops, falls;
        bit prev_req, prev_busy;
        int exp_rises, exp_drops, exp_cnt;
`ifdef PULSE_PEND_EN
        exp_rises = 2; exp_drops = 1; exp_cnt = 1;
`else
        exp_rises = 1; exp_drops = 2; exp_cnt = 2;
`endif
        do_reset();
        resp_mode = 0; resp_delay = 3; resp_rand = 0;
        rises = 0; dones = 0; drops = 0; falls = 0;
        prev_req = 0; prev_busy = 0;
        for (int i = 0; i < 45; i++) begin
            step((i == 0) || (i == 2) || (i == 4));
            if (req_a && !prev_req) rises++;
            if (!busy_a && prev_busy) falls++;
            if (done_a) dones++;
            if (drop_a) drops++;
            prev_req  = req_a;
            prev_busy = busy_a;
        end
        checks++;
        if (rises != exp_rises) begin errors++; $display("FAIL three_req_rises: got %0d want %0d", rises, exp_rises); end
        checks++;
        if (dones != exp_rises) begin errors++; $display("FAIL three_done_count: got %0d want %0d", dones, exp_rises); end
        checks++;
        if (drops != exp_drops) begin errors++; $display("FAIL three_drop_pulses: got %0d want %0d", drops, exp_drops); end
        checks++;
        if (drop_cnt_a !== 8'(exp_cnt)) begin errors++; $display("FAIL three_drop_cnt: got %0d want %0d", drop_cnt_a, exp_cnt); end
        checks++;
        if (falls != 1) begin errors++; $display("FAIL three_busy_gaps: busy fell %0d times want 1", falls); end
    endtask

    task automatic test_saturate();
        do_reset();
        resp_mode = 1;
        step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b1);
        checks++;
        if (drop_cnt_a !== 8'd255 || m_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_cnt: got %0d model %0d want 255", drop_cnt_a, m_cnt);
        end
        for (int i = 0; i < 5; i++) step(1'b1);
        checks++;
        if (drop_cnt_a !== 8'd255 || req_a !== 1'b1) begin
            errors++; $display("FAIL sat_hold: got cnt %0d req %0b want 255 1", drop_cnt_a, req_a);
        end
        resp_mode = 0;
    endtask

    task automatic test_reset_mid();
        int guard;
        int done_at;
        do_reset();
        resp_mode = 0; resp_delay = 3; resp_rand = 0;
        step(1'b1); step(1'b1); step(1'b1);
        guard = 0;
        while (ack_b !== 1'b1 && guard < 10) begin step(1'b0); guard++; end
        checks++;
        if (ack_b !== 1'b1 || req_a !== 1'b1 || drop_cnt_a !== m_cnt || m_cnt == 8'd0) begin
            errors++;
            $display("FAIL mid_pre: got ack %0b req %0b cnt %0d want 1 1 %0d (nonzero)", ack_b, req_a, drop_cnt_a, m_cnt);
        end
        resp_mode = 2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_a, busy_a, done_a, drop_cnt_a} !== 11'h000) begin
            errors++;
            $display("FAIL mid_reset: got req %0b busy %0b done %0b cnt %0d want all 0", req_a, busy_a, done_a, drop_cnt_a);
        end
        @(posedge clka);
        @(negedge clka);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0);
        step(1'b1);
        checks++;
        if ({req_a, busy_a} !== 2'b11) begin errors++; $display("FAIL stale_req: got req %0b busy %0b want 1 1", req_a, busy_a); end
        step(1'b0);
        checks++;
        if ({req_a, busy_a, done_a} !== 3'b010) begin
            errors++; $display("FAIL stale_release: got req %0b busy %0b done %0b want 0 1 0", req_a, busy_a, done_a);
        end
        ack_b = 1'b0;
        done_at = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            if (done_a && done_at < 0) done_at = i;
        end
        checks++;
        if (done_at != 3 || busy_a !== 1'b0) begin
            errors++; $display("FAIL stale_done: got done at %0d busy %0b want 3 0", done_at, busy_a);
        end
        resp_mode = 0;
    endtask

    task automatic test_exit_pulse();
        int guard;
        do_reset();
        resp_mode = 0; resp_delay = 3; resp_rand = 0;
        step(1'b1);
        guard = 0;
        while (!(m_busy && !m_req && !m_hist[1]) && guard < 30) begin step(1'b0); guard++; end
        checks++;
        if (guard >= 30) begin errors++; $display("FAIL exit_wait: got timeout want exit edge"); end
        step(1'b1);
        checks++;
`ifdef PULSE_PEND_EN
        if ({done_a, req_a, drop_a, drop_cnt_a} !== {3'b110, 8'd0}) begin
            errors++;
            $display("FAIL exit_pulse: got done %0b req %0b drop %0b cnt %0d want 1 1 0 0", done_a, req_a, drop_a, drop_cnt_a);
        end
`else
        if ({done_a, req_a, drop_a, drop_cnt_a} !== {3'b101, 8'd1}) begin
            errors++;
            $display("FAIL exit_pulse: got done %0b req %0b drop %0b cnt %0d want 1 0 1 1", done_a, req_a, drop_a, drop_cnt_a);
        end
`endif
    endtask

    task automatic test_random();
        logic [11:0] obs, exp;
        do_reset();
        resp_mode = 0; resp_rand = 1; resp_delay = 3;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 30);
            obs = {req_a, busy_a, done_a, drop_a, drop_cnt_a};
            exp = {m_req, m_busy, m_done, m_drop, m_cnt};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", i, obs, exp);
            end
        end
        resp_rand = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_three_pulses();
        test_saturate();
        test_reset_mid();
        test_exit_pulse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
